rv_ctl_datapath: RTL and testbench

- Control and execute slice of the multicycle RV32I core: the multicycle FSM, the instruction decoder and the ALU in one block.
- Takes the instruction register, PC and register-file read data.
- Produces memory/PC/IR strobes, register-file indices and controls, the decoded immediate, the ALU result and the writeback data.
- Sits between the IR/PC registers and the general-purpose register file.

---
 rtl/rv_ctl_datapath.sv | 205 ++++++++++++++++++++
 tb/tb_rv_ctl_datapath.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctl_datapath.sv
// Multicycle RV32I control/execute slice: FETCH/DECODE/EXECUTE/WRITEBACK FSM, decoder and ALU.
// Optional ILLEGAL_TRAP_EN: unsupported opcodes raise illegal_o and park the FSM in HALT.
module rv_ctl_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ce_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            fetch_en_o,
  output logic            pc_inc_o,
  output logic            pc_in_sel_o,
  output logic [4:0]      rd_idx_o,
  output logic [4:0]      rs1_idx_o,
  output logic [4:0]      rs2_idx_o,
  output logic [XLEN-1:0] imm_o,
  output logic            gp_regfile_ce_o,
  output logic            regfile_we_o,
  output logic [XLEN-1:0] rd_in_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t state_q, state_d;

  logic            pc_in_sel_q, pc_in_sel_d;
  logic            we_q, we_d;
  logic [1:0]      rd_in_sel_q, rd_in_sel_d;
  logic            rs1_sel_q, rs1_sel_d;
  logic            rs2_sel_q, rs2_sel_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_idx_q, rs1_idx_q, rs2_idx_q;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic            illegal_d;
`ifdef ILLEGAL_TRAP_EN
  logic            illegal_q;
`endif

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   state_q <= S_FETCH;
    else if (ce_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
`ifdef ILLEGAL_TRAP_EN
      S_DECODE:    state_d = illegal_d ? S_HALT : S_EXECUTE;
`else
      S_DECODE:    state_d = S_EXECUTE;
`endif
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    fetch_en_o      = (state_q == S_FETCH);
    pc_inc_o        = (state_q == S_WRITEBACK);
    gp_regfile_ce_o = (state_q == S_WRITEBACK);
    regfile_we_o    = (state_q == S_WRITEBACK) && we_q;
  end

  // Unsupported opcodes fall through with reset-value controls, i.e. a NOP.
  always_comb begin
    pc_in_sel_d = 1'b1;
    we_d        = 1'b0;
    rd_in_sel_d = 2'b00;
    rs1_sel_d   = 1'b1;
    rs2_sel_d   = 1'b0;
    alu_sel_d   = 4'b0000;
    imm_d       = '0;
    illegal_d   = 1'b0;
    case (opcode)
      OP_OP: begin
        we_d = 1'b1; rd_in_sel_d = 2'b10; rs2_sel_d = 1'b1;
        alu_sel_d = {instr_i[30], funct3};
      end
      OP_IMM: begin
        we_d = 1'b1; rd_in_sel_d = 2'b10; imm_d = imm_i;
        alu_sel_d = {(funct3 == 3'b101) && instr_i[30], funct3};
      end
      OP_LUI: begin
        we_d = 1'b1; rd_in_sel_d = 2'b01; imm_d = imm_u;
      end
      OP_AUIPC: begin
        we_d = 1'b1; rd_in_sel_d = 2'b10; rs1_sel_d = 1'b0; imm_d = imm_u;
      end
      OP_JAL: begin
        we_d = 1'b1; pc_in_sel_d = 1'b0; rs1_sel_d = 1'b0; imm_d = imm_j;
      end
      OP_JALR: begin
        we_d = 1'b1; pc_in_sel_d = 1'b0; imm_d = imm_i;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  logic [XLEN-1:0] lhs, rhs;
  logic [4:0]      shamt;

  assign lhs   = rs1_sel_q ? rs1_i : pc_i;
  assign rhs   = rs2_sel_q ? rs2_i : imm_q;
  assign shamt = rhs[4:0];

  always_comb begin
    alu_result_d = lhs + rhs;
    casez (alu_sel_q)
      4'b0000: alu_result_d = lhs + rhs;
      4'b1000: alu_result_d = lhs - rhs;
      4'b?001: alu_result_d = lhs << shamt;
      4'b?010: alu_result_d = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
      4'b?011: alu_result_d = {{(XLEN-1){1'b0}}, lhs < rhs};
      4'b?100: alu_result_d = lhs ^ rhs;
      4'b0101: alu_result_d = lhs >> shamt;
      4'b1101: alu_result_d = $unsigned($signed(lhs) >>> shamt);
      4'b?110: alu_result_d = lhs | rhs;
      4'b?111: alu_result_d = lhs & rhs;
      default: alu_result_d = lhs + rhs;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_in_sel_q  <= 1'b1;
      we_q         <= 1'b0;
      rd_in_sel_q  <= 2'b00;
      rs1_sel_q    <= 1'b1;
      rs2_sel_q    <= 1'b0;
      alu_sel_q    <= 4'b0000;
      imm_q        <= '0;
      rd_idx_q     <= '0;
      rs1_idx_q    <= '0;
      rs2_idx_q    <= '0;
      alu_result_q <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else if (ce_i) begin
      if (state_q == S_DECODE) begin
        pc_in_sel_q <= pc_in_sel_d;
        we_q        <= we_d;
        rd_in_sel_q <= rd_in_sel_d;
        rs1_sel_q   <= rs1_sel_d;
        rs2_sel_q   <= rs2_sel_d;
        alu_sel_q   <= alu_sel_d;
        imm_q       <= imm_d;
        rd_idx_q    <= instr_i[11:7];
        rs1_idx_q   <= instr_i[19:15];
        rs2_idx_q   <= instr_i[24:20];
`ifdef ILLEGAL_TRAP_EN
        illegal_q   <= illegal_d;
`endif
      end
      if (state_q == S_EXECUTE) alu_result_q <= alu_result_d;
    end
  end

  always_comb begin
    case (rd_in_sel_q)
      2'b01:   rd_in_o = imm_q;
      2'b10:   rd_in_o = alu_result_q;
      default: rd_in_o = pc_i + XLEN'(4);
    endcase
  end

  assign pc_in_sel_o  = pc_in_sel_q;
  assign rd_idx_o     = rd_idx_q;
  assign rs1_idx_o    = rs1_idx_q;
  assign rs2_idx_o    = rs2_idx_q;
  assign imm_o        = imm_q;
  assign alu_result_o = alu_result_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o    = illegal_q;
`else
  assign illegal_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rv_ctl_datapath.sv
// Self-checking bench for rv_ctl_datapath: directed RV32I cases plus random instructions
// checked against an instruction-level reference model.
module tb_rv_ctl_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0;
  logic        fetch_en, pc_inc, pc_in_sel, gp_regfile_ce, regfile_we, illegal;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm, rd_in, alu_result;
  logic [3:0]  strobes;

  int tests = 0;
  int failed = 0;

  rv_ctl_datapath #(.XLEN(32)) dut (
    .clk_i(clk), .reset_i(reset), .ce_i(ce), .instr_i(instr), .pc_i(pc),
    .rs1_i(rs1), .rs2_i(rs2), .fetch_en_o(fetch_en), .pc_inc_o(pc_inc),
    .pc_in_sel_o(pc_in_sel), .rd_idx_o(rd_idx), .rs1_idx_o(rs1_idx),
    .rs2_idx_o(rs2_idx), .imm_o(imm), .gp_regfile_ce_o(gp_regfile_ce),
    .regfile_we_o(regfile_we), .rd_in_o(rd_in), .alu_result_o(alu_result),
    .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  assign strobes = {fetch_en, pc_inc, gp_regfile_ce, regfile_we};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Architectural effect of one instruction: write enable, rd value, next PC, ALU value.
  task automatic ref_model(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] b, output bit we, output logic [31:0] rdv,
                           output logic [31:0] npc, output logic [31:0] alu, output bit alu_valid);
    logic [31:0] ii, iu, ij;
    ii = {{20{ins[31]}}, ins[31:20]};
    iu = {ins[31:12], 12'h000};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    we = 1'b1; alu_valid = 1'b1; npc = p + 4; alu = '0; rdv = '0;
    case (ins[6:0])
      7'b0110011: begin alu = arith(ins[14:12], ins[30], a, b); rdv = alu; end
      7'b0010011: begin alu = arith(ins[14:12], ins[14:12] == 3'd5 && ins[30], a, ii); rdv = alu; end
      7'b0110111: begin rdv = iu; alu_valid = 1'b0; end
      7'b0010111: begin alu = p + iu; rdv = alu; end
      7'b1101111: begin alu = p + ij; rdv = p + 4; npc = alu & ~32'd1; end
      7'b1100111: begin alu = a + ii; rdv = p + 4; npc = alu & ~32'd1; end
      default:    begin we = 1'b0; alu_valid = 1'b0; end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0;
    step(); step();
    reset = 1'b0; ce = 1'b1;
  endtask

  // Starts in FETCH at posedge+1; ends in the next FETCH.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] b);
    bit we, av;
    logic [31:0] rdv, npc, alu, got_npc;
    ref_model(ins, p, a, b, we, rdv, npc, alu, av);
    instr = ins; pc = p; rs1 = a; rs2 = b; ce = 1'b1;
    tests++;
    if (strobes !== 4'b1000) begin failed++; $display("FAIL %s fetch strobes got %b want 1000", name, strobes); end
    step();
    tests++;
    if (strobes !== 4'b0000) begin failed++; $display("FAIL %s decode strobes got %b want 0000", name, strobes); end
    step();
    tests++;
    if (strobes !== 4'b0000) begin failed++; $display("FAIL %s execute strobes got %b want 0000", name, strobes); end
    step();
    tests++;
    if (strobes !== {3'b011, we}) begin failed++; $display("FAIL %s wb strobes got %b want %b", name, strobes, {3'b011, we}); end
    tests++;
    if ({rd_idx, rs1_idx, rs2_idx} !== {ins[11:7], ins[19:15], ins[24:20]}) begin
      failed++; $display("FAIL %s indices got %h want %h", name, {rd_idx, rs1_idx, rs2_idx}, {ins[11:7], ins[19:15], ins[24:20]});
    end
    got_npc = pc_in_sel ? pc + 4 : {alu_result[31:1], 1'b0};
    tests++;
    if (got_npc !== npc) begin failed++; $display("FAIL %s next_pc got %h want %h", name, got_npc, npc); end
    if (we) begin
      tests++;
      if (rd_in !== rdv) begin failed++; $display("FAIL %s rd_in got %h want %h", name, rd_in, rdv); end
    end
    if (av) begin
      tests++;
      if (alu_result !== alu) begin failed++; $display("FAIL %s alu_result got %h want %h", name, alu_result, alu); end
    end
    step();
  endtask

  task automatic test_reset();
    pc = 32'h0000_1000;
    reset = 1'b1; ce = 1'b1;
    step();
    tests++;
    if (strobes !== 4'b1000) begin failed++; $display("FAIL reset_strobes got %b want 1000", strobes); end
    tests++;
    if ({alu_result, imm} !== 64'd0) begin failed++; $display("FAIL reset_regs got %h want 0", {alu_result, imm}); end
    tests++;
    if ({rd_idx, rs1_idx, rs2_idx, pc_in_sel, illegal} !== {15'd0, 1'b1, 1'b0}) begin
      failed++; $display("FAIL reset_ctl got %b want %b", {rd_idx, rs1_idx, rs2_idx, pc_in_sel, illegal}, {15'd0, 1'b1, 1'b0});
    end
    tests++;
    if (rd_in !== 32'h0000_1004) begin failed++; $display("FAIL reset_rd_in got %h want 00001004", rd_in); end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    run_instr("addi", 32'h0050_0093, 32'h0, 32'h0, 32'h0);
    tests++;
    if (rd_in !== 32'd5) begin failed++; $display("FAIL addi_rd_in_after got %h want 5", rd_in); end
  endtask

  task automatic test_directed();
    run_instr("sub",   32'h4020_81B3, 32'h0,  32'd3,          32'd5);
    run_instr("sra",   32'h4020_D233, 32'h0,  32'h8000_0000,  32'd4);
    run_instr("lui",   32'h1234_52B7, 32'h0,  32'h5555_5555,  32'h0);
    run_instr("auipc", 32'h1234_5297, 32'h100, 32'h0,         32'h0);
    run_instr("jalr",  32'h0041_00E7, 32'h40, 32'h203,        32'hDEAD_BEEF);
    run_instr("jal",   32'hFF9F_F0EF, 32'h200, 32'h0,         32'h0);
    run_instr("srai",  32'h4041_5093, 32'h0,  32'hF000_0000,  32'h0);
    run_instr("slti",  32'hFFF1_2093, 32'h0,  32'hFFFF_FFFE,  32'h0);
  endtask

  task automatic test_random();
    logic [6:0]  ops [7] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                            7'b1101111, 7'b1100111, 7'b1100011};
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins, a, b;
      int k;
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 6);
`endif
      ins = {$urandom} & 32'hFFFF_FF80;
      ins[6:0] = ops[k];
      if (k == 0) ins[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'b0};
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_instr($sformatf("rand%0d", n), ins, $urandom & 32'hFFFF_FFFC, a, b);
    end
  endtask

  task automatic test_ce_stall();
    run_instr("pre_stall", 32'h0050_0093, 32'h0, 32'h0, 32'h0);
    instr = 32'h0020_81B3; rs1 = 32'd10; rs2 = 32'd7;
    step(); step();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({strobes, alu_result} !== {4'b0000, 32'd5}) begin
        failed++; $display("FAIL stall_exec%0d got %b/%h want 0000/00000005", i, strobes, alu_result);
      end
    end
    ce = 1'b1;
    step();
    tests++;
    if ({strobes, rd_in} !== {4'b0111, 32'd17}) begin
      failed++; $display("FAIL stall_wb got %b/%h want 0111/00000011", strobes, rd_in);
    end
    ce = 1'b0;
    step(); step();
    tests++;
    if (strobes !== 4'b0111) begin failed++; $display("FAIL stall_wb_hold got %b want 0111", strobes); end
    ce = 1'b1;
    step();
    tests++;
    if (strobes !== 4'b1000) begin failed++; $display("FAIL stall_resume got %b want 1000", strobes); end
  endtask

  task automatic test_reset_mid();
    instr = 32'h0050_0093; rs1 = '0; rs2 = '0;
    step(); step(); step();
    tests++;
    if (regfile_we !== 1'b1) begin failed++; $display("FAIL mid_wb_we got %b want 1", regfile_we); end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (strobes !== 4'b1000) begin failed++; $display("FAIL mid_reset_strobes got %b want 1000", strobes); end
    step();
    reset = 1'b0;
    run_instr("after_reset", 32'h0030_8113, 32'h80, 32'd4, 32'h0);
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    instr = 32'h0000_007F;
    step(); step();
    for (int i = 0; i < 6; i++) begin
      tests++;
      if ({illegal, strobes} !== 5'b10000) begin
        failed++; $display("FAIL halt%0d got %b want 10000", i, {illegal, strobes});
      end
      step();
    end
    do_reset();
    tests++;
    if ({illegal, strobes} !== 5'b01000) begin failed++; $display("FAIL halt_reset got %b want 01000", {illegal, strobes}); end
`else
    run_instr("illegal_nop", 32'h0000_007F, 32'h300, 32'h1, 32'h2);
    tests++;
    if (illegal !== 1'b0) begin failed++; $display("FAIL illegal_flag got %b want 0", illegal); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_directed();
    test_random();
    test_ce_stall();
    test_reset_mid();
    test_illegal();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
